// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the sequential signed divider
package booth_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int DW = 32;
  localparam int QW = 16;
  localparam int CNT_W = 5;
  localparam logic [15:0] QMAX_POS = 16'd32767;
  localparam logic [16:0] QMAX_NEG = 17'd32768;
endpackage

// File: rtl/div_iter.sv
// div_iter: one combinational restoring-division step (shift in a dividend bit, trial subtract)
module div_iter
  import booth_pkg::*;
(
  input  logic [QW:0]   r,
  input  logic          q_msb,
  input  logic [QW-1:0] d,
  output logic [QW:0]   r_next,
  output logic          bit_q
);
  logic [QW:0]   t;
  logic [QW+1:0] sum;
  assign t = {r[QW-1:0], q_msb};
  // t + ~d + 1: the carry out is set exactly when t >= d
  assign sum = {1'b0, t} + {1'b0, ~{1'b0, d}} + {{(QW + 1){1'b0}}, 1'b1};
  assign bit_q = sum[QW+1];
  assign r_next = bit_q ? sum[QW:0] : t;
endmodule

// File: rtl/booth_div.sv
// booth_div: 32/16 signed restoring divider, one quotient bit per clock, valid/ready on both sides
module booth_div
  import booth_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [QW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quotient,
  output logic [QW-1:0] remainder,
  output logic          div_zero,
  output logic          ovf
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [QW:0]      r;
  logic [QW-1:0]    q;
  logic [QW-1:0]    d_abs;
  logic [QW-1:0]    rem_raw;
  logic             sign_n;
  logic             sign_q;
  logic             dz;
  logic             pre_ovf;
  logic [DW-1:0]    n_in_abs;
  logic [QW-1:0]    d_in_abs;
  logic             in_dz;
  logic             in_ovf;
  logic [QW:0]      r_next;
  logic             bit_q;
  logic             fix_ovf;
  logic             any_ovf;
  assign n_in_abs = dividend[DW-1] ? -dividend : dividend;
  assign d_in_abs = divisor[QW-1] ? -divisor : divisor;
  assign in_dz = divisor == '0;
  // a quotient needing more than 16 magnitude bits is caught before iterating
  assign in_ovf = !in_dz && n_in_abs[DW-1:QW] >= d_in_abs;
  assign fix_ovf = sign_q ? {1'b0, q} > QMAX_NEG : q > QMAX_POS;
  assign any_ovf = pre_ovf || fix_ovf;
  div_iter u_iter (
    .r      (r),
    .q_msb  (q[QW-1]),
    .d      (d_abs),
    .r_next (r_next),
    .bit_q  (bit_q)
  );
  // control FSM with operand, iteration and registered result state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      d_abs     <= '0;
      rem_raw   <= '0;
      sign_n    <= 1'b0;
      sign_q    <= 1'b0;
      dz        <= 1'b0;
      pre_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          sign_n   <= dividend[DW-1];
          sign_q   <= dividend[DW-1] ^ divisor[QW-1];
          d_abs    <= d_in_abs;
          rem_raw  <= dividend[QW-1:0];
          r        <= {1'b0, n_in_abs[DW-1:QW]};
          q        <= n_in_abs[QW-1:0];
          cnt      <= '0;
          dz       <= in_dz;
          pre_ovf  <= in_ovf;
          state    <= (in_dz || in_ovf) ? FIX : CALC;
        end
        CALC: begin
          r     <= r_next;
          q     <= {q[QW-2:0], bit_q};
          cnt   <= cnt + 1'b1;
          state <= (cnt == CNT_W'(QW - 1)) ? FIX : CALC;
        end
        FIX: begin
          out_valid <= 1'b1;
          div_zero  <= dz;
          ovf       <= !dz && any_ovf;
          quotient  <= (dz || any_ovf) ? '0 : sign_q ? -q : q;
          remainder <= dz ? rem_raw : any_ovf ? '0 : sign_n ? -r[QW-1:0] : r[QW-1:0];
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_div.sv
// tb_booth_div: random and directed checks of booth_div against an arithmetic reference model
module tb_booth_div;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;
  logic        ovf;
  int          n_chk = 0;
  int          n_err = 0;

  booth_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (dividend=0x%08h divisor=0x%04h)", tag, got, exp, dividend, divisor);
    end
  endtask

  // truncating signed division evaluated on wide integers
  function automatic void model(input logic [31:0] n, input logic [15:0] d,
                                output logic [15:0] eq, output logic [15:0] er,
                                output logic edz, output logic eov, output int elat);
    longint ln, ld, lq, lr;
    ln = longint'($signed(n));
    ld = longint'($signed(d));
    eq = '0; er = '0; edz = 1'b0; eov = 1'b0; elat = 1;
    if (ld == 0) begin
      edz = 1'b1;
      er = n[15:0];
    end else begin
      lq = ln / ld;
      lr = ln - lq * ld;
      if (lq > 32767 || lq < -32768) begin
        eov = 1'b1;
        elat = (lq >= 65536 || lq <= -65536) ? 1 : 17;
      end else begin
        eq = 16'(lq);
        er = 16'(lr);
        elat = 17;
      end
    end
  endfunction

  task automatic op(input logic [31:0] n, input logic [15:0] d, input int hold);
    logic [15:0] eq, er;
    logic edz, eov;
    int elat, lat;
    model(n, d, eq, er, edz, eov, elat);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dividend = n;
    divisor = d;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (lat < 40 && !out_valid) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, elat);
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("quotient", {16'd0, quotient}, {16'd0, eq});
      chk("remainder", {16'd0, remainder}, {16'd0, er});
      chk("div_zero", {31'd0, div_zero}, {31'd0, edz});
      chk("ovf", {31'd0, ovf}, {31'd0, eov});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] corner [6];
    logic [31:0] n;
    logic [15:0] d;
    corner = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0007};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", {16'd0, quotient}, 32'd0);
    chk("rst_remainder", {16'd0, remainder}, 32'd0);
    chk("rst_flags", {30'd0, div_zero, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    op(32'h000186A0, 16'd7, 0);
    op(32'hFFFE7960, 16'd7, 0);
    op(32'h40000000, 16'h8000, 0);
    op(32'h40000000, 16'h7FFF, 0);
    op(32'h7FFFFFFF, 16'h0001, 0);
    op(32'h00001234, 16'h0000, 0);
    op(32'h00000000, 16'hFFF3, 5);
    op(32'h80000000, 16'hFFFF, 2);
    op(32'h80000000, 16'h8000, 0);
    // abort mid-iteration with reset, then confirm a clean restart
    in_valid = 1'b1;
    dividend = 32'h00123456;
    divisor = 16'h0123;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    op(32'hFFFE7960, 16'hFFF9, 0);
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0: begin n = $urandom; d = 16'($urandom); end
        1: begin
          d = 16'($urandom);
          n = 32'($signed(16'($urandom)) * $signed(d)) + 32'($signed(16'($urandom_range(0, 200)) - 16'd100));
        end
        2: begin n = $urandom; d = corner[$urandom_range(0, 5)]; end
        default: begin n = 32'($signed(20'($urandom))); d = 16'($signed(8'($urandom))); end
      endcase
      op(n, d, $urandom_range(0, 2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
